// File: rtl/fp_pkg.sv
// Shared single-precision float definitions for the power-function datapath:
// field widths, sequencer states and field-slice helpers.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned FP_W   = 1 + EXP_W + MANT_W;
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned CNT_W  = $clog2(SIG_W);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM
    } state_t;

    function automatic logic f_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] f_mant(input logic [FP_W-1:0] x);
        return x[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/seq_mant_mul.sv
// 24x24 shift-add significand multiplier: one multiplier bit per step,
// LSB first, into a 48-bit accumulator.
module seq_mant_mul
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [SIG_W-1:0]  mcand,
    input  logic [SIG_W-1:0]  mplier,
    output logic              last_c,
    output logic [PROD_W-1:0] prod
);

    logic [SIG_W-1:0] mcand_q;
    logic [SIG_W-1:0] mplier_q;
    logic [CNT_W-1:0] cnt;

    assign last_c = (cnt == CNT_W'(SIG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt      <= '0;
            prod     <= '0;
        end else if (load) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            cnt      <= '0;
            prod     <= '0;
        end else if (step) begin
            if (mplier_q[cnt]) begin
                prod <= prod + (PROD_W'(mcand_q) << cnt);
            end
            cnt <= last_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle single-precision multiplier with truncating normalisation and
// saturating overflow/underflow handling; fixed 25-edge latency.
module fp_mul_seq
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [FP_W-1:0] p,
    output logic            ovf,
    output logic            unf
);

    localparam int unsigned E_W = EXP_W + 2;
    localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
    localparam logic signed [E_W-1:0] E_ZERO = '0;

    state_t            state;
    logic              sign_q;
    logic              zero_q;
    logic [EXP_W-1:0]  ea_q;
    logic [EXP_W-1:0]  eb_q;
    logic              load_c;
    logic              step_c;
    logic              last_c;
    logic [PROD_W-1:0] prod;

    logic signed [E_W-1:0] e_raw_c;
    logic signed [E_W-1:0] e_norm_c;
    logic [MANT_W-1:0]     mant_c;
    logic [FP_W-1:0]       res_c;
    logic                  ovf_c;
    logic                  unf_c;

    assign load_c = (state == IDLE) && start;
    assign step_c = (state == MUL);

    seq_mant_mul u_mant_mul (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .step   (step_c),
        .mcand  ({1'b1, f_mant(a)}),
        .mplier ({1'b1, f_mant(b)}),
        .last_c (last_c),
        .prod   (prod)
    );

    // Normalise the product (it lies in [2^46, 2^48)) and apply zero/ovf/unf rules.
    always_comb begin
        res_c    = '0;
        ovf_c    = 1'b0;
        unf_c    = 1'b0;
        e_raw_c  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - E_BIAS;
        e_norm_c = prod[PROD_W-1] ? (e_raw_c + E_ONE) : e_raw_c;
        mant_c   = prod[PROD_W-1] ? prod[PROD_W-2 -: MANT_W] : prod[PROD_W-3 -: MANT_W];
        if (zero_q) begin
            res_c = {sign_q, {(FP_W-1){1'b0}}};
        end else if (e_norm_c >= E_MAX) begin
            res_c = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            ovf_c = 1'b1;
        end else if (e_norm_c <= E_ZERO) begin
            res_c = {sign_q, {(FP_W-1){1'b0}}};
            unf_c = 1'b1;
        end else begin
            res_c = {sign_q, e_norm_c[EXP_W-1:0], mant_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= f_sign(a) ^ f_sign(b);
                        zero_q <= (f_exp(a) == '0) || (f_exp(b) == '0);
                        ea_q   <= f_exp(a);
                        eb_q   <= f_exp(b);
                        busy   <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (last_c) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    p     <= res_c;
                    ovf   <= ovf_c;
                    unf   <= unf_c;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: products, zero/ovf/unf cases, latency,
// ignored start, back-to-back start and mid-operation reset.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p;
    logic        ovf;
    logic        unf;

    int tests;
    int failed;

    fp_mul_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and check result, flags and the 25-edge latency.
    task automatic do_mul(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ep, input logic eovf, input logic eunf);
        int n;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd25);
        check({tag, "_p"}, p, ep);
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        check({tag, "_unf"}, 32'(unf), 32'(eunf));
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcnt;
        int first;
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_p", p, 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_mul("m15x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("p_hold", p, 32'h40400000);

        do_mul("m15x15", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
        do_mul("mneg", 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);
        // back-to-back: next start lands in the done cycle
        do_mul("mzero", 32'h80000000, 32'h40490FDB, 32'h80000000, 1'b0, 1'b0);
        do_mul("movf", 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);
        do_mul("munf", 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1);
        do_mul("mrestore", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);

        // start re-pulsed at E5 with different operands must be ignored
        @(negedge clk);
        a = 32'h3FC00000;
        b = 32'h3FC00000;
        start = 1'b1;
        @(posedge clk);
        #1;
        dcnt  = 0;
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin
                a = 32'h7F000000;
                b = 32'h7F000000;
            end
            @(posedge clk);
            #1;
            if (k == 5) check("ign_busy", 32'(busy), 32'd1);
            if (done) begin
                dcnt++;
                first = k;
            end
        end
        start = 1'b0;
        check("ign_done_count", 32'(dcnt), 32'd1);
        check("ign_done_edge", 32'(first), 32'd25);
        check("ign_p", p, 32'h40100000);
        check("ign_ovf", 32'(ovf), 32'd0);

        // reset at E10 aborts the operation
        @(negedge clk);
        a = 32'h40000000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_p", p, 32'h0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        check("abort_p_hold", p, 32'h0);

        do_mul("after_rst", 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Multi-cycle IEEE-754 single-precision multiplier for the power-function datapath. It produces x·x and x·term products that feed the registered float adder directly downstream. The multiplier takes operands on a start/busy/done handshake and multiplies the mantissas with a 24-iteration shift-add loop. It returns a truncated, normalised 32-bit product with overflow and underflow flags.

## Interface
- EXP_W, 8, exponent field width
- MANT_W, 23, stored mantissa width (hidden bit excluded)
- BIAS, 127, exponent bias
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when FSM is IDLE
- a  in  32  operand A, IEEE-754 single
- b  in  32  operand B, IEEE-754 single
- busy  out  1  high while a multiplication is in progress
- done  out  1  one-cycle pulse; p/ovf/unf valid from this cycle
- p  out  32  product, held until next done
- ovf  out  1  result overflowed to ±inf; held with p
- unf  out  1  result underflowed to ±0; held with p

## Operation
- FSM states: IDLE, MUL, NORM.
- IDLE -> MUL on start=1. a and b are latched at that edge, the iteration counter is cleared, and the 48-bit accumulator is cleared.
- MUL: 24 cycles, counter 0..23. Each cycle adds the shifted multiplicand {1,ma} to the accumulator when bit[counter] of {1,mb} is set. After counter 23 the FSM goes to NORM.
- NORM: one cycle. It registers p, ovf and unf, pulses done, and returns to IDLE.
- Sign = sa XOR sb, always, including zero and overflow results.
- Zero rule: an exponent field of 0 (zero or denormal) on either operand gives p = {sign, 31'b0} with ovf=0 and unf=0. Latency is unchanged.
- Exponent: e = ea + eb − BIAS, computed as 10-bit signed.
- Product prod[47:0] always lies in [2^46, 2^48):
  - prod[47]=1: mantissa = prod[46:24], e = e+1.
  - prod[47]=0: mantissa = prod[45:23].
- Rounding: truncation only, with no guard/sticky bits. This matches the downstream adder.
- Overflow: e ≥ 255 gives p = {sign, 8'hFF, 23'b0} and ovf=1.
- Underflow: e ≤ 0 gives p = {sign, 31'b0} and unf=1.
- Exponent field 255 on an input is not special-cased; it is treated as a normal exponent and will overflow.
- start while busy=1 is ignored; no queueing.

## Timing
- Reset values: busy=0, done=0, p=0, ovf=0, unf=0, FSM=IDLE, counter=0.
- Let E0 be the edge that samples start.
  - busy rises at E0.
  - MUL covers edges E1..E24.
  - p/ovf/unf/done update at E25.
  - busy falls at E25.
  - done is high for the single cycle after E25.
- Latency is fixed at 25 edges from start to done, independent of operand values.
- Back-to-back: start asserted in the done cycle is accepted, because the FSM is already IDLE. Maximum throughput is one result per 26 cycles.
- rst during MUL/NORM aborts the operation and returns all outputs to their reset values at that edge. No done is issued for the aborted operation.
- Between results, p/ovf/unf hold their last values; they are never cleared by a new start.

## Structure
- Shared package fp_pkg:
  - EXP_W, MANT_W, BIAS constants.
  - FSM state typedef (IDLE, MUL, NORM).
  - Sign/exponent/mantissa field-slice helpers, reused by the adder and later stages.
- Sub-module seq_mant_mul: 24×24 shift-add mantissa multiplier with load/step/last signals and a 48-bit accumulator.
- Top level holds the FSM, the exponent/sign path and normalisation.

## Test plan
- a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> p=0x40400000 (3.0), ovf=0, unf=0, done exactly 25 edges after start.
- a=0x3FC00000, b=0x3FC00000 (1.5·1.5, prod[47] set path) -> p=0x40100000 (2.25).
- a=0xC0000000 (−2), b=0x40400000 (3) -> p=0xC0C00000 (−6); then a=0x80000000, b=0x40490FDB -> p=0x80000000, ovf=0, unf=0.
- a=0x7F000000, b=0x40000000 -> p=0x7F800000, ovf=1; a=0x00800000, b=0x3F000000 -> p=0x00000000, unf=1.
- start pulsed again at E5 of an operation -> ignored, single done, busy stays high. Start in the done cycle -> second result 25 edges later.
- rst asserted at E10 -> busy=0, p=0 at the next edge, no done. A new start afterwards completes normally.
